// File: rtl/scale_freq_pkg.sv
// Shared types and constants for the scale-constrained target frequency selector.
// ROM holds octave-7 pitches in unsigned Q16.16; lower octaves are right shifts.
package scale_freq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEARCH,
      ST_LOOKUP
   } state_t;

   localparam int Q_W     = 32;
   localparam int NUM_PCS = 12;
   localparam int MAX_OCT = 7;

   localparam logic [Q_W-1:0] ROM_C  = 32'h082D0128;
   localparam logic [Q_W-1:0] ROM_CS = 32'h08A97607;
   localparam logic [Q_W-1:0] ROM_D  = 32'h092D5172;
   localparam logic [Q_W-1:0] ROM_DS = 32'h09B90410;
   localparam logic [Q_W-1:0] ROM_E  = 32'h0A4D053D;
   localparam logic [Q_W-1:0] ROM_F  = 32'h0AE9D36B;
   localparam logic [Q_W-1:0] ROM_FS = 32'h0B8FF494;
   localparam logic [Q_W-1:0] ROM_G  = 32'h0C3FF6A7;
   localparam logic [Q_W-1:0] ROM_GS = 32'h0CFA7005;
   localparam logic [Q_W-1:0] ROM_A  = 32'h0DC00000;
   localparam logic [Q_W-1:0] ROM_AS = 32'h0E914F62;
   localparam logic [Q_W-1:0] ROM_B  = 32'h0F6F1100;

   typedef struct packed {
      logic [3:0] pc;
      logic [2:0] oct;
      logic       blocked;
   } step_t;

   // One semitone step with pitch-class wrap; blocked when the octave would leave 0..7.
   function automatic step_t step_cand(input logic [3:0] pc, input logic [2:0] oct,
                                       input logic up);
      step_t s;
      s.pc      = pc;
      s.oct     = oct;
      s.blocked = 1'b0;
      if (up) begin
         if (pc == 4'(NUM_PCS - 1)) begin
            if (oct == 3'(MAX_OCT)) begin
               s.blocked = 1'b1;
            end else begin
               s.pc  = 4'd0;
               s.oct = oct + 3'd1;
            end
         end else begin
            s.pc = pc + 4'd1;
         end
      end else begin
         if (pc == 4'd0) begin
            if (oct == 3'd0) begin
               s.blocked = 1'b1;
            end else begin
               s.pc  = 4'(NUM_PCS - 1);
               s.oct = oct - 3'd1;
            end
         end else begin
            s.pc = pc - 4'd1;
         end
      end
      return s;
   endfunction

endpackage

// File: rtl/scale_freq_select_rom.sv
// Combinational octave-7 frequency table, one Q16.16 word per pitch class.
module scale_freq_rom
   import scale_freq_pkg::*;
(
   input  logic [3:0]     i_pc,
   output logic [Q_W-1:0] o_word
);

   always_comb begin
      case (i_pc)
         4'd0:    o_word = ROM_C;
         4'd1:    o_word = ROM_CS;
         4'd2:    o_word = ROM_D;
         4'd3:    o_word = ROM_DS;
         4'd4:    o_word = ROM_E;
         4'd5:    o_word = ROM_F;
         4'd6:    o_word = ROM_FS;
         4'd7:    o_word = ROM_G;
         4'd8:    o_word = ROM_GS;
         4'd9:    o_word = ROM_A;
         4'd10:   o_word = ROM_AS;
         4'd11:   o_word = ROM_B;
         default: o_word = '0;
      endcase
   end

endmodule

// File: rtl/scale_freq_select.sv
// Nearest in-scale note search with start/done handshake, Q16.16 frequency out.
// SCALE_FREQ_SELECT_SINGLE_CYCLE_EN swaps the per-cycle walk for a one-cycle resolve.
module scale_freq_select
   import scale_freq_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  note_name,
   input  logic [2:0]  note_octave,
   input  logic        greater,
   input  logic [11:0] scale,
   input  logic        start,
   output logic        done,
   output logic [31:0] freq_desired
);

   localparam logic [2:0] OCT_TOP = 3'(MAX_OCT);

   state_t         r_state;
   logic [3:0]     r_note_pc;
   logic [2:0]     r_note_oct;
   logic           r_up;
   logic [11:0]    r_scale;
   logic           r_invalid;
   logic [3:0]     r_pc;
   logic [2:0]     r_oct;
   logic [3:0]     r_sel_pc;
   logic [2:0]     r_sel_oct;
   logic           r_done;
   logic [Q_W-1:0] r_freq;

   logic [Q_W-1:0] w_rom_word;
   logic [2:0]     w_shamt;
   logic [Q_W-1:0] w_freq;

   scale_freq_rom u_rom (
      .i_pc   (r_sel_pc),
      .o_word (w_rom_word)
   );

   assign w_shamt = OCT_TOP - r_sel_oct;
   assign w_freq  = w_rom_word >> w_shamt;

`ifdef SCALE_FREQ_SELECT_SINGLE_CYCLE_EN
   logic [3:0] w_fast_pc;
   logic [2:0] w_fast_oct;
   logic [3:0] w_walk_pc;
   logic [2:0] w_walk_oct;
   logic       w_walk_end;
   step_t      w_walk_step;

   // Unrolled walk: first in-scale candidate wins, otherwise the original note.
   always_comb begin
      w_fast_pc   = r_note_pc;
      w_fast_oct  = r_note_oct;
      w_walk_pc   = r_pc;
      w_walk_oct  = r_oct;
      w_walk_end  = 1'b0;
      w_walk_step = '0;
      for (int k = 0; k < NUM_PCS; k++) begin
         if (!w_walk_end) begin
            if (r_scale[w_walk_pc]) begin
               w_fast_pc  = w_walk_pc;
               w_fast_oct = w_walk_oct;
               w_walk_end = 1'b1;
            end else begin
               w_walk_step = step_cand(w_walk_pc, w_walk_oct, r_up);
               if (w_walk_step.blocked) begin
                  w_walk_end = 1'b1;
               end else begin
                  w_walk_pc  = w_walk_step.pc;
                  w_walk_oct = w_walk_step.oct;
               end
            end
         end
      end
   end
`else
   logic [3:0] r_cnt;
   step_t      w_step;

   assign w_step = step_cand(r_pc, r_oct, r_up);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_done  <= 1'b0;
         r_freq  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_note_pc  <= note_name;
                  r_note_oct <= note_octave;
                  r_up       <= greater;
                  r_scale    <= scale;
                  r_invalid  <= (note_name >= 4'(NUM_PCS));
                  r_pc       <= note_name;
                  r_oct      <= note_octave;
`ifndef SCALE_FREQ_SELECT_SINGLE_CYCLE_EN
                  r_cnt      <= 4'd0;
`endif
                  r_state    <= ST_SEARCH;
               end
            end
            ST_SEARCH: begin
`ifdef SCALE_FREQ_SELECT_SINGLE_CYCLE_EN
               r_sel_pc  <= w_fast_pc;
               r_sel_oct <= w_fast_oct;
               r_state   <= ST_LOOKUP;
`else
               if (r_invalid) begin
                  r_state <= ST_LOOKUP;
               end else if (r_scale[r_pc]) begin
                  r_sel_pc  <= r_pc;
                  r_sel_oct <= r_oct;
                  r_state   <= ST_LOOKUP;
               end else if (r_cnt == 4'(NUM_PCS - 1) || w_step.blocked) begin
                  // Nothing reachable in scale: leave the pitch uncorrected.
                  r_sel_pc  <= r_note_pc;
                  r_sel_oct <= r_note_oct;
                  r_state   <= ST_LOOKUP;
               end else begin
                  r_pc  <= w_step.pc;
                  r_oct <= w_step.oct;
                  r_cnt <= r_cnt + 4'd1;
               end
`endif
            end
            ST_LOOKUP: begin
               r_freq  <= r_invalid ? '0 : w_freq;
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign done         = r_done;
   assign freq_desired = r_freq;

endmodule

// File: tb/tb_scale_freq_select.sv
// Directed bench for scale_freq_select: latency, frequency and reset behaviour.
module tb_scale_freq_select;

   logic        clk;
   logic        reset;
   logic [3:0]  note_name;
   logic [2:0]  note_octave;
   logic        greater;
   logic [11:0] scale;
   logic        start;
   logic        done;
   logic [31:0] freq_desired;

   int n_chk;
   int n_err;

   scale_freq_select dut (
      .clk          (clk),
      .reset        (reset),
      .note_name    (note_name),
      .note_octave  (note_octave),
      .greater      (greater),
      .scale        (scale),
      .start        (start),
      .done         (done),
      .freq_desired (freq_desired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request, count edges to done, then check value, pulse width and hold.
   task automatic run_req(input string tag, input logic [3:0] nn, input logic [2:0] no,
                          input logic up, input logic [11:0] sc,
                          input logic [31:0] exp_f, input int exp_e, input bit extra);
      int got_e;
      logic [31:0] got_f;
      got_e = -1;
      got_f = '0;
      @(negedge clk);
      note_name   = nn;
      note_octave = no;
      greater     = up;
      scale       = sc;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start       = 1'b0;
      note_name   = 4'd5;
      note_octave = 3'd1;
      greater     = ~up;
      scale       = ~sc;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (done) begin
            got_e = e;
            got_f = freq_desired;
            start = 1'b0;
            break;
         end
         start = (extra && e < 10) ? e[0] : 1'b0;
      end
      chk_val({tag, "_lat"}, 32'(got_e), 32'(exp_e));
      chk_val({tag, "_freq"}, got_f, exp_f);
      @(posedge clk);
      #1;
      chk_val({tag, "_pulse"}, {31'd0, done}, 32'd0);
      chk_val({tag, "_hold"}, freq_desired, exp_f);
   endtask

   initial begin
      int pulses;
      n_chk = 0;
      n_err = 0;
      reset = 1'b1;
      start = 1'b0;
      note_name = '0;
      note_octave = '0;
      greater = 1'b0;
      scale = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk_val("rst_done", {31'd0, done}, 32'd0);
      chk_val("rst_freq", freq_desired, 32'd0);

      run_req("d4_up",   4'd2,  3'd4, 1'b1, 12'b111111100000, 32'h015D3A6D, 5, 1'b0);
      run_req("d4_dn",   4'd2,  3'd4, 1'b0, 12'b111111100000, 32'h00F6F110, 5, 1'b0);
      run_req("a4_all",  4'd9,  3'd4, 1'b1, 12'hFFF,          32'h01B80000, 2, 1'b0);
      run_req("a4_none", 4'd9,  3'd4, 1'b1, 12'h000,          32'h01B80000, 13, 1'b1);
      run_req("b7_up",   4'd11, 3'd7, 1'b1, 12'b000000000001, 32'h0F6F1100, 2, 1'b0);
      run_req("b2_up",   4'd11, 3'd2, 1'b1, 12'b000000000001, 32'h0082D012, 3, 1'b0);
      run_req("c0_dn",   4'd0,  3'd0, 1'b0, 12'h800,          32'h00105A02, 2, 1'b0);
      run_req("e6_dn",   4'd4,  3'd6, 1'b0, 12'h002,          32'h0454BB03, 5, 1'b0);
      run_req("inval",   4'd13, 3'd3, 1'b1, 12'hFFF,          32'h00000000, 2, 1'b0);
      run_req("a4_back", 4'd9,  3'd4, 1'b0, 12'hFFF,          32'h01B80000, 2, 1'b0);

      // Abandon a long search with reset; no completion may follow.
      @(negedge clk);
      note_name   = 4'd9;
      note_octave = 3'd4;
      greater     = 1'b1;
      scale       = 12'h000;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      pulses = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk_val("midrst_freq", freq_desired, 32'd0);
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      chk_val("midrst_nodone", 32'(pulses), 32'd0);
      chk_val("midrst_freq_hold", freq_desired, 32'd0);

      run_req("post_rst", 4'd2, 3'd4, 1'b1, 12'b111111100000, 32'h015D3A6D, 5, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/scale_freq_select.md
# scale_freq_select

Pitch-correction target selector for the autotune datapath. Given the detected note (pitch class and octave) and whether the measured pitch lies above or below that note, it searches the active musical scale, in the direction indicated, for the nearest allowed note. It returns that note's frequency as a 32-bit fixed-point value. It sits between the pitch detector/note classifier and the pitch-shift ratio calculator, and is driven by a start/done handshake.

## Interface
Parameters: none.
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- note_name  in  4  detected pitch class, 0=C … 11=B; 12–15 invalid
- note_octave  in  3  detected octave, 0–7
- greater  in  1  1 = measured pitch above note (search upward); 0 = search downward
- scale  in  12  allowed pitch classes; bit i = pitch class i (bit0=C, bit11=B)
- start  in  1  request; sampled only in IDLE
- done  out  1  one-cycle pulse; freq_desired valid from this cycle
- freq_desired  out  32  target frequency in Hz, unsigned Q16.16; held until next completion

## Operation
- ROM holds 12 octave-7 frequencies: rom[n] = round(f·65536), where f = 440·2^((n−9)/12+3) Hz. For example, rom[9] = 3520 Hz = 0x0DC00000.
- Output frequency = rom[pc] >> (7 − octave), using a logical shift with truncation.
- FSM states:
  - IDLE: on start, latch all inputs, set cand_pc = note_name and cand_oct = note_octave, clear the step counter, go to SEARCH.
  - SEARCH: one candidate is checked per cycle.
    - If scale[cand_pc] = 1, go to LOOKUP with the candidate.
    - Otherwise step the candidate: up is pc+1, and 11 wraps to 0 with oct+1; down is pc−1, and 0 wraps to 11 with oct−1.
  - SEARCH fallbacks: each goes to LOOKUP with the original latched note, i.e. no correction.
    - 12 consecutive misses (scale = 0).
    - A step that would take the octave above 7 or below 0.
  - LOOKUP: register freq_desired, pulse done, return to IDLE.
- The candidate equal to the input note is checked first, so an in-scale note maps to itself.
- Invalid note_name (12–15): skip the search; freq_desired = 0 with normal done.
- start while not in IDLE is ignored. Inputs may change freely after the start cycle.
- Reset:
  - Returns to IDLE and clears done to 0 and freq_desired to 0.
  - Any search in progress is abandoned; no done is produced.

## Timing
- Edge 0 samples start. Let n = number of missed candidates (0–11).
- The hit or fallback is decided at edge n+1.
- freq_desired and done update at edge n+2; done is high for exactly that one cycle.
- Latency range:
  - Best case: done at edge 2.
  - Scale = 0: done at edge 13 (12 misses, fallback decided at edge 12).
  - Octave-bound fallback: decided at the edge where the illegal step would occur.
  - Invalid note_name: done at edge 2.
- start may be reasserted in the cycle after done; it is accepted at that edge.

## Configuration
- SCALE_FREQ_SELECT_SINGLE_CYCLE_EN:
  - Defined: the search is a combinational 12-way rotate-and-priority-encode in the requested direction, with the same fallback rules. SEARCH is removed, and done always occurs at edge 2.
  - Undefined: the iterative search described above. Results are identical in both builds.

## Structure
- Package scale_freq_pkg:
  - FSM state enum.
  - Q16.16 width constant.
  - NUM_PCS = 12 and MAX_OCT = 7.
  - The 12 octave-7 ROM constants.
- Sub-module scale_freq_rom: pitch class in, octave-7 Q16.16 word out (combinational).

## Test plan
- Reset asserted mid-search → done never pulses; freq_desired = 0; the next start completes normally.
- note=D(2), oct=4, greater=1, scale=12'b111111100000 → F4 = rom[5]>>3; done at edge 5.
- Same inputs with greater=0 → wraps down to B3 = rom[11]>>4; done at edge 5.
- note=A(9), oct=4, scale=12'hFFF → freq_desired = 0x01B80000 (440.0 Hz); done at edge 2.
- note=A, oct=4, scale=0 → 0x01B80000 via fallback; done at edge 13. Extra start pulses during the search are ignored.
- note=B(11), oct=7, greater=1, scale=12'b000000000001 → octave-bound fallback gives B7 = rom[11]. With oct=2, the same request gives C3 = rom[0]>>4.
